// File: rtl/ldpc_frame_sched_if.sv
// Stream, core-control and statistics signals of the LDPC frame scheduler.
// The scheduler takes the slave side; whoever feeds frames and models the core takes master.
interface ldpc_frame_sched_if #(
    parameter int FRAME_W = 4608,
    parameter int RES_W   = 576,
    parameter int ITER_W  = 8,
    parameter int STAT_W  = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [FRAME_W-1:0] in_sig;
    logic [ITER_W-1:0]  cfg_max_iter;
    logic [FRAME_W-1:0] core_sig;
    logic               core_load;
    logic               core_en;
    logic               core_syn_ok;
    logic [RES_W-1:0]   core_dec;
    logic               out_valid;
    logic               out_ready;
    logic [RES_W-1:0]   out_res;
    logic [1:0]         out_status;
    logic [ITER_W-1:0]  out_iters;
    logic               busy;
    logic [STAT_W-1:0]  stat_conv;
    logic [STAT_W-1:0]  stat_fail;

    modport master (
        output in_valid, in_sig, cfg_max_iter, core_syn_ok, core_dec, out_ready,
        input  in_ready, core_sig, core_load, core_en, out_valid, out_res,
               out_status, out_iters, busy, stat_conv, stat_fail
    );

    modport slave (
        input  in_valid, in_sig, cfg_max_iter, core_syn_ok, core_dec, out_ready,
        output in_ready, core_sig, core_load, core_en, out_valid, out_res,
               out_status, out_iters, busy, stat_conv, stat_fail
    );
endinterface

// File: rtl/ldpc_frame_sched.sv
// Frame sequencer for the LDPC decoder core: one-entry prefetch buffer, load,
// gated iterations until parity success or the iteration limit, then result hand-off.
module ldpc_frame_sched #(
    parameter int FRAME_W = 4608,
    parameter int RES_W   = 576,
    parameter int ITER_W  = 8,
    parameter int STAT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    ldpc_frame_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    state_t             state;
    logic               buf_full;
    logic [FRAME_W-1:0] buf_data;
    logic [ITER_W-1:0]  iter_cnt;
    logic [ITER_W-1:0]  lim;
    logic               accept;
    logic               in_iter;

    // The buffer can be refilled in the same cycle LOAD drains it.
    assign bus.in_ready = rst & (~buf_full | (state == LOAD));
    assign accept       = bus.in_valid & bus.in_ready;
    assign in_iter      = (state == ITER);
    assign bus.core_en  = in_iter & ~bus.core_syn_ok & (iter_cnt != lim);
    assign bus.busy     = (state != IDLE) | buf_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_full <= 1'b0;
        end else begin
            if (state == LOAD) begin
                buf_full <= 1'b0;
            end
            if (accept) begin
                buf_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_data <= bus.in_sig;
        end
    end

    // core_sig is set on entry to LOAD so it is already stable while core_load is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            iter_cnt       <= '0;
            lim            <= '0;
            bus.core_load  <= 1'b0;
            bus.core_sig   <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_res    <= '0;
            bus.out_status <= 2'b00;
            bus.out_iters  <= '0;
            bus.stat_conv  <= '0;
            bus.stat_fail  <= '0;
        end else begin
            bus.core_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (buf_full || accept) begin
                        state         <= LOAD;
                        bus.core_load <= 1'b1;
                        bus.core_sig  <= buf_full ? buf_data : bus.in_sig;
                    end
                end
                LOAD: begin
                    iter_cnt <= '0;
                    lim      <= (bus.cfg_max_iter == '0) ? ITER_W'(1) : bus.cfg_max_iter;
                    state    <= ITER;
                end
                ITER: begin
                    if (bus.core_syn_ok) begin
                        bus.out_res    <= bus.core_dec;
                        bus.out_status <= 2'b01;
                        bus.out_iters  <= iter_cnt;
                        bus.out_valid  <= 1'b1;
                        if (bus.stat_conv != {STAT_W{1'b1}}) begin
                            bus.stat_conv <= bus.stat_conv + 1'b1;
                        end
                        state <= DONE;
                    end else if (iter_cnt == lim) begin
                        bus.out_res    <= bus.core_dec;
                        bus.out_status <= 2'b10;
                        bus.out_iters  <= iter_cnt;
                        bus.out_valid  <= 1'b1;
                        if (bus.stat_fail != {STAT_W{1'b1}}) begin
                            bus.stat_fail <= bus.stat_fail + 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        iter_cnt <= iter_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (buf_full) begin
                            state         <= LOAD;
                            bus.core_load <= 1'b1;
                            bus.core_sig  <= buf_data;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ldpc_frame_sched.sv
// Scoreboard bench for ldpc_frame_sched: a behavioural core model converges after a
// per-frame number of enabled iterations; expected results come from plain min/compare rules.
module tb_ldpc_frame_sched;
    localparam int FRAME_W = 4608;
    localparam int RES_W   = 576;
    localparam int ITER_W  = 8;
    localparam int STAT_W  = 4;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ldpc_frame_sched_if #(.FRAME_W(FRAME_W), .RES_W(RES_W), .ITER_W(ITER_W), .STAT_W(STAT_W)) bus ();

    ldpc_frame_sched #(.FRAME_W(FRAME_W), .RES_W(RES_W), .ITER_W(ITER_W), .STAT_W(STAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [FRAME_W-1:0] frame;
        int                 conv_at;
        logic [ITER_W-1:0]  cfg;
    } load_t;

    typedef struct {
        logic [RES_W-1:0]  res;
        logic [1:0]        status;
        int                iters;
        logic [STAT_W-1:0] conv;
        logic [STAT_W-1:0] fail;
    } exp_t;

    load_t load_q[$];
    exp_t  exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int bp_mode = 0;
    int model_conv = 0;
    int model_fail = 0;

    logic [FRAME_W-1:0] cur_frame = '0;
    int                 cur_conv = 0;
    int                 en_cnt = 0;
    logic               active = 1'b0;

    function automatic logic [RES_W-1:0] model_dec(logic [FRAME_W-1:0] f, int n);
        logic [RES_W-1:0] m;
        for (int i = 0; i < RES_W / 32; i++) begin
            m[i*32 +: 32] = 32'(n * 32'h9E3779B1 + i);
        end
        return f[RES_W-1:0] ^ m;
    endfunction

    function automatic logic [FRAME_W-1:0] rand_frame();
        logic [FRAME_W-1:0] f;
        for (int i = 0; i < FRAME_W / 32; i++) begin
            f[i*32 +: 32] = $urandom;
        end
        return f;
    endfunction

    // Core model: hard decision depends on the frame and the iterations run so far.
    assign bus.core_syn_ok = active && (en_cnt >= cur_conv);
    assign bus.core_dec    = model_dec(cur_frame, en_cnt);

    always @(posedge clk) begin
        if (!rst) begin
            active <= 1'b0;
            en_cnt <= 0;
        end else if (bus.core_load && load_q.size() > 0) begin
            cur_frame <= load_q[0].frame;
            cur_conv  <= load_q[0].conv_at;
            active    <= 1'b1;
            en_cnt    <= 0;
            void'(load_q.pop_front());
        end else if (bus.core_en) begin
            en_cnt <= en_cnt + 1;
        end
        bus.cfg_max_iter <= (load_q.size() > 0) ? load_q[0].cfg : ITER_W'($urandom);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkWide(input string name, input logic [FRAME_W-1:0] act, input logic [FRAME_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got low64 0x%0h, expected low64 0x%0h", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic flagFail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: got timeout/unexpected event, expected normal progress", name);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pushes the expected response, then offers the frame until accepted.
    task automatic applyStimulus(input logic [FRAME_W-1:0] frame, input int cfg, input int conv_at,
                                 output int acc_cyc);
        load_t l;
        exp_t  e;
        int    lim;
        bit    acc;
        lim = (cfg == 0) ? 1 : cfg;
        e.res = '0;
        if (conv_at <= lim) begin
            e.status = 2'b01;
            e.iters  = conv_at;
            if (model_conv < int'(STAT_MAX)) model_conv++;
        end else begin
            e.status = 2'b10;
            e.iters  = lim;
            if (model_fail < int'(STAT_MAX)) model_fail++;
        end
        e.res  = model_dec(frame, e.iters);
        e.conv = STAT_W'(model_conv);
        e.fail = STAT_W'(model_fail);
        l.frame = frame;
        l.conv_at = conv_at;
        l.cfg = ITER_W'(cfg);
        exp_q.push_back(e);
        load_q.push_back(l);
        bus.in_sig = frame;
        bus.in_valid = 1'b1;
        acc = 0;
        acc_cyc = -1;
        for (int w = 0; w < 400 && !acc; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) flagFail("in_accept_timeout");
    endtask

    task automatic waitDrain();
        for (int w = 0; w < 4000 && exp_q.size() > 0; w++) step(1);
        if (exp_q.size() > 0) flagFail("drain_timeout");
        step(2);
    endtask

    // Monitor: core_sig checked on every load, results popped on every handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.core_load) begin
                    if (load_q.size() == 0) flagFail("core_load_unexpected");
                    else checkWide("core_sig", bus.core_sig, load_q[0].frame);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        flagFail("out_unexpected");
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checkWide("out_res", FRAME_W'(bus.out_res), FRAME_W'(e.res));
                        checkOutput("out_status", 64'(bus.out_status), 64'(e.status));
                        checkOutput("out_iters", 64'(bus.out_iters), 64'(e.iters));
                        checkOutput("core_en_count", 64'(en_cnt), 64'(e.iters));
                        checkOutput("stat_conv", 64'(bus.stat_conv), 64'(e.conv));
                        checkOutput("stat_fail", 64'(bus.stat_fail), 64'(e.fail));
                    end
                end
            end
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc_cyc;
        int seen;
        int cnt_a;
        int cnt_b;
        bus.in_valid = 1'b0;
        bus.in_sig = '0;
        rst = 1'b0;
        step(3);

        @(negedge clk);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_core_en", 64'(bus.core_en), 64'd0);
        checkOutput("rst_core_load", 64'(bus.core_load), 64'd0);
        checkWide("rst_out_res", FRAME_W'(bus.out_res), '0);
        checkOutput("rst_out_status", 64'(bus.out_status), 64'd0);
        checkOutput("rst_out_iters", 64'(bus.out_iters), 64'd0);
        checkOutput("rst_stat_conv", 64'(bus.stat_conv), 64'd0);
        checkOutput("rst_stat_fail", 64'(bus.stat_fail), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        step(1);
        rst = 1'b1;
        bp_mode = 0;
        step(3);

        // Convergence after 3 iterations, with accept-to-valid latency.
        applyStimulus(rand_frame(), 10, 3, acc_cyc);
        seen = 0;
        for (int w = 0; w < 60 && !seen; w++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        if (!seen) flagFail("latency_timeout");
        else checkOutput("latency", 64'(cyc - acc_cyc), 64'd6);
        step(1);
        waitDrain();

        // Timeout at the limit, and the zero limit treated as one.
        applyStimulus(rand_frame(), 4, NEVER, acc_cyc);
        waitDrain();
        applyStimulus(rand_frame(), 0, NEVER, acc_cyc);
        waitDrain();

        // Backpressure: second frame buffered, third refused, core stalled.
        bp_mode = 2;
        step(3);
        applyStimulus(rand_frame(), 3, 1, acc_cyc);
        applyStimulus(rand_frame(), 3, 2, acc_cyc);
        bus.in_sig = rand_frame();
        bus.in_valid = 1'b1;
        seen = 0;
        for (int w = 0; w < 60 && !seen; w++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        if (!seen) flagFail("stall_valid_timeout");
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) cnt_a++;
            if (bus.core_en) cnt_b++;
        end
        checkOutput("stall_in_ready_cycles", 64'(cnt_a), 64'd0);
        checkOutput("stall_core_en_cycles", 64'(cnt_b), 64'd0);
        checkOutput("stall_busy", 64'(bus.busy), 64'd1);
        step(1);
        bus.in_valid = 1'b0;
        bp_mode = 0;
        seen = 0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) seen = 1;
        end
        if (!seen) flagFail("release_timeout");
        cnt_a = 0;
        @(negedge clk);
        checkOutput("release_core_load", 64'(bus.core_load), 64'd1);
        if (bus.core_load) cnt_a++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.core_load) cnt_a++;
        end
        checkOutput("release_load_pulses", 64'(cnt_a), 64'd1);
        step(1);
        waitDrain();

        // Reset mid-iteration with a frame buffered.
        applyStimulus(rand_frame(), 50, NEVER, acc_cyc);
        applyStimulus(rand_frame(), 50, NEVER, acc_cyc);
        step(5);
        rst = 1'b0;
        exp_q.delete();
        load_q.delete();
        model_conv = 0;
        model_fail = 0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_rst_core_en", 64'(bus.core_en), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("mid_rst_out_iters", 64'(bus.out_iters), 64'd0);
        checkOutput("mid_rst_stat_fail", 64'(bus.stat_fail), 64'd0);
        step(1);
        rst = 1'b1;
        step(2);
        applyStimulus(rand_frame(), 6, 2, acc_cyc);
        waitDrain();

        // Randomized traffic with random output backpressure.
        bp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            int conv;
            conv = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 14));
            applyStimulus(rand_frame(), int'($urandom_range(0, 12)), conv, acc_cyc);
            step(int'($urandom_range(0, 3)));
        end
        waitDrain();
        bp_mode = 0;
        step(2);

        // Saturation of the convergence counter.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(rand_frame(), 5, 1, acc_cyc);
        end
        waitDrain();
        checkOutput("stat_conv_saturated", 64'(bus.stat_conv), 64'(STAT_MAX));
        applyStimulus(rand_frame(), 5, 0, acc_cyc);
        waitDrain();
        checkOutput("stat_conv_held", 64'(bus.stat_conv), 64'(STAT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
